// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT of 2-bit saturating counters with a post-reset clear sweep,
// registered mispredict pulse and saturating branch/mispredict statistics.
module branch_predictor_bht #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic             ready,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam logic [1:0]  CNT_WNT = 2'b01;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_BITS-1:0] r_init_idx;
  logic [IDX_BITS-1:0] w_init_idx_nxt;
  logic                w_init_wr;
  logic                w_init_last;
  logic                w_upd_acc;
  logic                w_miss;

  logic [1:0]          r_bht [ENTRIES];
  logic [IDX_BITS-1:0] w_pred_idx;
  logic [IDX_BITS-1:0] w_upd_idx;
  logic [1:0]          w_upd_cur;
  logic [1:0]          w_upd_nxt;

  logic                r_ready;
  logic                r_mispredict;
  logic [CNT_W-1:0]    r_br_count;
  logic [CNT_W-1:0]    r_miss_count;

  // Only the index field of each PC is used; the rest aliases by design.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                              upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  assign w_pred_idx = pred_pc[IDX_BITS+1:2];
  assign w_upd_idx  = upd_pc[IDX_BITS+1:2];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
    end
  end

  // Next-state and update-accept decode
  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    w_init_wr      = 1'b0;
    w_init_last    = 1'b0;
    w_upd_acc      = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_wr      = 1'b1;
        w_init_idx_nxt = r_init_idx + IDX_BITS'(1);
        w_init_last    = (r_init_idx == IDX_BITS'(ENTRIES - 1));
        if (w_init_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_upd_acc = upd_valid;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign w_miss = w_upd_acc & (upd_taken ^ upd_pred);

  // Saturating 2-bit counter step for the resolving branch
  always_comb begin
    w_upd_cur = r_bht[w_upd_idx];
    w_upd_nxt = w_upd_cur;
    if (upd_taken) begin
      if (w_upd_cur != 2'b11) w_upd_nxt = w_upd_cur + 2'(1);
    end else begin
      if (w_upd_cur != 2'b00) w_upd_nxt = w_upd_cur - 2'(1);
    end
  end

  // Table storage is not reset; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init_wr) begin
        r_bht[r_init_idx] <= CNT_WNT;
      end else if (w_upd_acc) begin
        r_bht[w_upd_idx] <= w_upd_nxt;
      end
    end
  end

  // Registered status and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready      <= 1'b0;
      r_mispredict <= 1'b0;
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_init_last) r_ready <= 1'b1;
      r_mispredict <= w_miss;
      if (w_upd_acc && !(&r_br_count)) r_br_count <= r_br_count + CNT_W'(1);
      if (w_miss && !(&r_miss_count)) r_miss_count <= r_miss_count + CNT_W'(1);
    end
  end

  assign pred_taken = r_ready & r_bht[w_pred_idx][1];
  assign ready      = r_ready;
  assign mispredict = r_mispredict;
  assign br_count   = r_br_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: a default instance plus a CNT_W=4
// instance for statistics saturation.
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  logic [31:0] s_pred_pc;
  logic        s_pred_taken;
  logic        s_ready;
  logic        s_upd_valid;
  logic [31:0] s_upd_pc;
  logic        s_upd_taken;
  logic        s_upd_pred;
  logic        s_mispredict;
  logic [3:0]  s_br_count;
  logic [3:0]  s_miss_count;

  int n_checks;
  int n_fail;

  branch_predictor_bht dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .ready(ready), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_pred(upd_pred), .mispredict(mispredict),
    .br_count(br_count), .miss_count(miss_count)
  );

  branch_predictor_bht #(.IDX_BITS(6), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pred_pc(s_pred_pc), .pred_taken(s_pred_taken),
    .ready(s_ready), .upd_valid(s_upd_valid), .upd_pc(s_upd_pc),
    .upd_taken(s_upd_taken), .upd_pred(s_upd_pred), .mispredict(s_mispredict),
    .br_count(s_br_count), .miss_count(s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted-or-not update on the default instance; returns #1 after its edge.
  task automatic do_upd(input logic [31:0] pc, input logic tk, input logic pd);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = tk;
    upd_pred  = pd;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic [31:0] pc, input logic exp_pt,
                           input logic exp_mp, input int exp_br, input int exp_miss);
    pred_pc = pc;
    #1;
    n_checks++;
    if (pred_taken !== exp_pt || mispredict !== exp_mp ||
        br_count !== 32'(exp_br) || miss_count !== 32'(exp_miss)) begin
      n_fail++;
      $display("FAIL %s: got pt=%b mp=%b br=%0d miss=%0d, want pt=%b mp=%b br=%0d miss=%0d",
               name, pred_taken, mispredict, br_count, miss_count,
               exp_pt, exp_mp, exp_br, exp_miss);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (ready !== 1'b0 || mispredict !== 1'b0 || br_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hold: ready=%b mp=%b br=%0d miss=%0d, want all 0",
               ready, mispredict, br_count, miss_count);
    end
    rst = 1'b0;
    bad = 0;
    for (int e = 1; e <= 63; e++) begin
      pred_pc = 32'(e * 4);
      tick();
      if (ready !== 1'b0 || pred_taken !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL init_sweep: %0d of edges 1..63 had ready/pred_taken high, want 0", bad);
    end
    tick();
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_edge64: ready=%b want 1", ready);
    end
    chk_state("after_init_0x100", 32'h100, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_training();
    do_upd(32'h40, 1'b1, 1'b0);
    chk_state("train1_WT", 32'h40, 1'b1, 1'b1, 1, 1);
    do_upd(32'h40, 1'b1, 1'b0);
    chk_state("train2_ST", 32'h40, 1'b1, 1'b1, 2, 2);
    tick();
    chk_state("train_mp_clear", 32'h40, 1'b1, 1'b0, 2, 2);
  endtask

  task automatic test_hysteresis();
    do_upd(32'h40, 1'b0, 1'b1);
    chk_state("hyst_ST_to_WT", 32'h40, 1'b1, 1'b1, 3, 3);
    do_upd(32'h40, 1'b0, 1'b0);
    chk_state("hyst_WT_to_WNT", 32'h40, 1'b0, 1'b0, 4, 3);
    for (int i = 0; i < 5; i++) do_upd(32'h40, 1'b0, 1'b0);
    chk_state("hyst_sat_low", 32'h40, 1'b0, 1'b0, 9, 3);
    // From 00, one taken step must still predict not-taken, two must predict taken.
    do_upd(32'h40, 1'b1, 1'b1);
    chk_state("hyst_00_to_01", 32'h40, 1'b0, 1'b0, 10, 3);
    do_upd(32'h40, 1'b1, 1'b1);
    chk_state("hyst_01_to_10", 32'h40, 1'b1, 1'b0, 11, 3);
  endtask

  task automatic test_aliasing();
    do_upd(32'h40, 1'b1, 1'b1);
    chk_state("alias_0x40_ST", 32'h40, 1'b1, 1'b0, 12, 3);
    chk_state("alias_0x140", 32'h140, 1'b1, 1'b0, 12, 3);
    chk_state("alias_0x44", 32'h44, 1'b0, 1'b0, 12, 3);
    chk_state("alias_0x42", 32'h42, 1'b1, 1'b0, 12, 3);
  endtask

  task automatic test_same_cycle_and_init_upd();
    int bad;
    pred_pc   = 32'h80;
    upd_valid = 1'b1;
    upd_pc    = 32'h80;
    upd_taken = 1'b1;
    upd_pred  = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_no_bypass: pred_taken=%b want 0", pred_taken);
    end
    tick();
    upd_valid = 1'b0;
    chk_state("same_cycle_next", 32'h80, 1'b1, 1'b1, 13, 4);

    rst = 1'b1;
    tick();
    rst       = 1'b0;
    upd_valid = 1'b1;
    upd_pc    = 32'h80;
    upd_taken = 1'b1;
    upd_pred  = 1'b0;
    chk_state("midrun_rst", 32'h80, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_rst_ready: ready=%b want 0", ready);
    end
    bad = 0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (mispredict !== 1'b0 || br_count !== 32'd0 || miss_count !== 32'd0) bad++;
      if (e < 64 && ready !== 1'b0) bad++;
    end
    upd_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL init_ignores_upd: %0d bad samples, want 0", bad);
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reinit_ready: ready=%b want 1", ready);
    end
    chk_state("reinit_0x80_WNT", 32'h80, 1'b0, 1'b0, 0, 0);
    chk_state("reinit_0x40_WNT", 32'h40, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_stat_saturation();
    int exp_n;
    s_pred_pc = 32'h0;
    n_checks++;
    if (s_ready !== 1'b1 || s_br_count !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_start: ready=%b br=%0d want ready=1 br=0", s_ready, s_br_count);
    end
    for (int i = 1; i <= 20; i++) begin
      s_upd_valid = 1'b1;
      s_upd_pc    = 32'h200;
      s_upd_taken = i[0];
      s_upd_pred  = ~i[0];
      tick();
      s_upd_valid = 1'b0;
      exp_n = (i > 15) ? 15 : i;
      n_checks++;
      if (s_mispredict !== 1'b1 || s_br_count !== 4'(exp_n) || s_miss_count !== 4'(exp_n)) begin
        n_fail++;
        $display("FAIL sat_upd%0d: mp=%b br=%0d miss=%0d, want mp=1 br=%0d miss=%0d",
                 i, s_mispredict, s_br_count, s_miss_count, exp_n, exp_n);
      end
    end
    tick();
    n_checks++;
    if (s_mispredict !== 1'b0 || s_br_count !== 4'hF || s_miss_count !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_hold: mp=%b br=%h miss=%h, want mp=0 br=f miss=f",
               s_mispredict, s_br_count, s_miss_count);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    pred_pc     = '0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_taken   = 1'b0;
    upd_pred    = 1'b0;
    s_pred_pc   = '0;
    s_upd_valid = 1'b0;
    s_upd_pc    = '0;
    s_upd_taken = 1'b0;
    s_upd_pred  = 1'b0;
    test_reset();
    test_training();
    test_hysteresis();
    test_aliasing();
    test_same_cycle_and_init_upd();
    test_stat_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Dynamic branch predictor that consumes the branch_taken resolution from the branch comparator and supplies a taken/not-taken prediction to fetch/next-PC logic.
- Holds a direct-mapped branch history table (BHT) of 2-bit saturating counters, indexed by PC.
- Clears itself with a sequential init sweep after reset.
- Reports a registered mispredict pulse and running branch/mispredict statistics.

Parameters:
- IDX_BITS, 6, log2 of BHT entry count (64 entries); index = pc[IDX_BITS+1:2].
- CNT_W, 32, width of statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pred_pc  input  32  fetch PC to predict.
- pred_taken  output  1  prediction for pred_pc; combinational from table.
- ready  output  1  high when init sweep is done and the table is valid.
- upd_valid  input  1  a conditional branch (opcode 1100011) resolves this cycle.
- upd_pc  input  32  PC of the resolving branch.
- upd_taken  input  1  actual outcome (comparator branch_taken).
- upd_pred  input  1  prediction that was used for this branch at fetch.
- mispredict  output  1  registered, 1-cycle pulse on an outcome/prediction mismatch.
- br_count  output  CNT_W  number of accepted updates.
- miss_count  output  CNT_W  number of accepted mispredicts.

Behaviour:
- Reset (rst=1 at a clk edge): state<=INIT, init_idx<=0, ready<=0, mispredict<=0, br_count<=0, miss_count<=0. Table contents are not cleared by rst directly.
- rst has priority over every other input at all times. Asserting rst mid-operation or mid-INIT restarts the sweep at index 0.
- State machine has two states, INIT and RUN.
  - INIT: each cycle, entry[init_idx]<=2'b01 (weakly not-taken) and init_idx<=init_idx+1. On the edge that writes entry 2^IDX_BITS-1, state<=RUN and ready<=1.
  - With defaults, ready rises on the 64th rising edge after the rst edge (the edge that samples rst=0 is sweep edge 1).
  - RUN: remains until rst.
- Prediction: pred_taken = ready & entry[pred_pc[IDX_BITS+1:2]][1]. It is purely combinational with no latency. pc bits [1:0] and bits above IDX_BITS+1 are ignored, so aliasing is permitted.
- Update is accepted only when state==RUN && upd_valid. In INIT, upd_valid is ignored: no table write, no counter change, no mispredict.
- Counter update (accepted):
  - upd_taken=1: counter increments, saturating at 2'b11.
  - upd_taken=0: counter decrements, saturating at 2'b00.
  - The write occurs at the clk edge and is visible to pred_taken from the next cycle.
- Same-index read and update in one cycle: pred_taken shows the pre-update value (no bypass).
- mispredict is registered: it is 1 in the cycle after an accepted update with upd_taken != upd_pred, and 0 otherwise. It is driven from upd_pred, not from the table. Back-to-back mismatches give consecutive 1s.
- Statistics:
  - br_count increments by 1 per accepted update.
  - miss_count increments by 1 per accepted mismatch, on the same edge that sets mispredict.
  - Both counters saturate at all-ones and never wrap.
- Transition states: 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction is the MSB of the counter.
- There is no X propagation: all outputs are defined from the first edge with rst=1.

Test Plan:
1. Reset/init: hold rst 3 cycles, release -> ready=0 and pred_taken=0 for any pred_pc until the 64th edge; ready=1 after it. At that point pred_pc=0x100 gives pred_taken=0 (WNT) and all counters read 0.
2. Training: pc=0x40, two updates upd_taken=1, upd_pred=0 -> after 1st update pred_taken(0x40)=1 (WT); after 2nd, ST. mispredict pulses on each following cycle; br_count=2, miss_count=2.
3. Saturation/hysteresis: from ST at 0x40, one update taken=0, pred=1 -> pred_taken stays 1 (WT) and miss_count+1. A second not-taken update -> pred_taken=0. Five further not-taken updates keep the counter at 00.
4. Aliasing/indexing: train 0x40 to ST. Then pred_pc=0x140 -> pred_taken=1 (alias). pred_pc=0x44 -> 0 (different index). pred_pc=0x42 -> 1 (low bits ignored).
5. Same-cycle read/write plus update during INIT: with 0x80 at WNT, pred_pc=0x80 and a taken update in the same cycle -> pred_taken=0 that cycle, 1 next cycle. Assert rst mid-RUN, then drive upd_valid=1 during INIT -> ready=0, counters=0, no mispredict. After the sweep, 0x80 reads WNT again.
6. Stat saturation (CNT_W=4 override): 20 mismatching updates -> br_count=miss_count=4'hF and held; mispredict still pulses each time.
